// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, default multi-cycle mask and sequencer state type
// for the ALU opcode sequencer.
package alu_seq_pkg;

  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_AND  = 2;
  localparam int unsigned OP_OR   = 3;
  localparam int unsigned OP_SLL  = 4;
  localparam int unsigned OP_SRA  = 5;
  localparam int unsigned OP_MUL  = 6;
  localparam int unsigned OP_DIV  = 7;
  localparam int unsigned OP_LAST = OP_DIV;

  localparam logic [7:0] MULTI_MASK_DEF = 8'b1100_0000;

  typedef enum logic [1:0] {
    StIdle,
    StSingle,
    StMulti,
    StDone
  } seq_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot unit enable, multi-cycle flag and legality.
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned         OPW        = 5,
  parameter int unsigned         NUM_OPS    = 8,
  parameter logic [NUM_OPS-1:0]  MULTI_MASK = NUM_OPS'(MULTI_MASK_DEF)
) (
  input  logic [OPW-1:0]     opcode_i,
  output logic [NUM_OPS-1:0] onehot_o,
  output logic               is_multi_o,
  output logic               is_legal_o
);

  always_comb begin
    onehot_o   = '0;
    is_multi_o = 1'b0;
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      if (32'(opcode_i) == k) begin
        onehot_o[k] = 1'b1;
        is_multi_o  = MULTI_MASK[k];
      end
    end
    is_legal_o = (32'(opcode_i) < NUM_OPS) && (32'(opcode_i) <= OP_LAST);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU opcode sequencer for single- and multi-cycle functional units.
// Optional `illegal` completion qualifier is enabled by defining ALU_SEQ_ILLEGAL_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned        OPW        = 5,
  parameter int unsigned        NUM_OPS    = 8,
  parameter logic [NUM_OPS-1:0] MULTI_MASK = NUM_OPS'(MULTI_MASK_DEF),
  parameter int unsigned        TIMEOUT    = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW-1:0]     in_opcode,
  output logic [NUM_OPS-1:0] mod_enable,
  output logic               mod_start,
  input  logic               unit_done,
  output logic               out_valid,
  output logic [OPW-1:0]     out_opcode,
  output logic               timed_out,
  output logic               busy
`ifdef ALU_SEQ_ILLEGAL_EN
  ,
  output logic               illegal
`endif
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  seq_state_e         state_q, state_d;
  logic [NUM_OPS-1:0] en_q, en_d;
  logic [OPW-1:0]     op_q, op_d;
  logic               start_q, start_d;
  logic               to_q, to_d;
  logic               ill_q, ill_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [NUM_OPS-1:0] dec_onehot;
  logic               dec_multi;
  logic               dec_legal;
  logic               accept;

  alu_op_decode #(
    .OPW       (OPW),
    .NUM_OPS   (NUM_OPS),
    .MULTI_MASK(MULTI_MASK)
  ) u_decode (
    .opcode_i  (in_opcode),
    .onehot_o  (dec_onehot),
    .is_multi_o(dec_multi),
    .is_legal_o(dec_legal)
  );

  assign in_ready = !reset && (state_q != StMulti);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    op_d    = op_q;
    start_d = 1'b0;
    to_d    = 1'b0;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StMulti: begin
        // unit_done is ignored during the mod_start cycle; it beats a same-cycle timeout.
        if (unit_done && !start_q) begin
          state_d = StDone;
        end else if ((TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT)) begin
          state_d = StDone;
          to_d    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (accept) begin
          state_d = dec_multi ? StMulti : StSingle;
          en_d    = dec_onehot;
          op_d    = in_opcode;
          start_d = dec_multi;
          ill_d   = !dec_legal;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
          en_d    = '0;
          ill_d   = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      en_q    <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      to_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      op_q    <= op_d;
      start_q <= start_d;
      to_q    <= to_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mod_enable = en_q;
  assign mod_start  = start_q;
  assign out_valid  = (state_q == StSingle) || (state_q == StDone);
  assign out_opcode = op_q;
  assign timed_out  = to_q;
  assign busy       = (state_q != StIdle);

`ifdef ALU_SEQ_ILLEGAL_EN
  assign illegal = ill_q && out_valid;
`else
  logic unused_ill;
  assign unused_ill = ill_q ^ dec_legal;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed test-plan scenarios plus
// randomized traffic, checked every cycle against a transaction-level model.
module tb_alu_op_sequencer;

  localparam int unsigned TO = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_opcode = '0;
  logic [7:0] mod_enable;
  logic       mod_start;
  logic       unit_done = 1'b0;
  logic       out_valid;
  logic [4:0] out_opcode;
  logic       timed_out;
  logic       busy;
`ifdef ALU_SEQ_ILLEGAL_EN
  logic       illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(
    .OPW    (5),
    .NUM_OPS(8),
    .TIMEOUT(TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .mod_enable(mod_enable),
    .mod_start (mod_start),
    .unit_done (unit_done),
    .out_valid (out_valid),
    .out_opcode(out_opcode),
    .timed_out (timed_out),
    .busy      (busy)
`ifdef ALU_SEQ_ILLEGAL_EN
    ,
    .illegal   (illegal)
`endif
  );

  always #5 clock = ~clock;

  // Model: an op in flight is either finished next cycle (single) or waits for
  // done / timeout, tracked by cycles elapsed since its mod_start cycle.
  bit       m_multi   = 1'b0;
  int       m_elapsed = 0;
  bit [7:0] e_en      = '0;
  bit       e_start   = 1'b0;
  bit       e_valid   = 1'b0;
  bit [4:0] e_op      = '0;
  bit       e_to      = 1'b0;
  bit       e_ill     = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_multi   <= 1'b0;
      m_elapsed <= 0;
      e_en      <= '0;
      e_start   <= 1'b0;
      e_valid   <= 1'b0;
      e_op      <= '0;
      e_to      <= 1'b0;
      e_ill     <= 1'b0;
    end else if (m_multi) begin
      e_start <= 1'b0;
      if (m_elapsed != 0 && unit_done) begin
        m_multi <= 1'b0;
        e_valid <= 1'b1;
        e_to    <= 1'b0;
      end else if (m_elapsed == TO) begin
        m_multi <= 1'b0;
        e_valid <= 1'b1;
        e_to    <= 1'b1;
      end else begin
        m_elapsed <= m_elapsed + 1;
      end
    end else if (in_valid) begin
      e_op      <= in_opcode;
      e_en      <= (in_opcode < 8) ? 8'(1 << in_opcode) : 8'h00;
      e_ill     <= (in_opcode > 7);
      e_to      <= 1'b0;
      m_elapsed <= 0;
      if (in_opcode == 6 || in_opcode == 7) begin
        m_multi <= 1'b1;
        e_start <= 1'b1;
        e_valid <= 1'b0;
      end else begin
        e_start <= 1'b0;
        e_valid <= 1'b1;
      end
    end else begin
      e_en    <= '0;
      e_start <= 1'b0;
      e_valid <= 1'b0;
      e_to    <= 1'b0;
      e_ill   <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(!m_multi && !reset));
    chk("mod_enable", 32'(mod_enable), 32'(e_en));
    chk("mod_start", 32'(mod_start), 32'(e_start));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) chk("out_opcode", 32'(out_opcode), 32'(e_op));
    chk("timed_out", 32'(timed_out), 32'(e_valid && e_to));
    chk("busy", 32'(busy), 32'(m_multi || e_valid));
    chk("onehot", 32'($countones(mod_enable) <= 1), 32'd1);
`ifdef ALU_SEQ_ILLEGAL_EN
    chk("illegal", 32'(illegal), 32'(e_valid && e_ill));
`endif
  endtask

  task automatic step(input bit v, input logic [4:0] op, input bit d);
    in_valid  = v;
    in_opcode = op;
    unit_done = d;
    @(negedge clock);
    check_all();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_all();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_opcode", 32'(out_opcode), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // ADD
    step(1, 5'd0, 0);
    chk("add_en", 32'(mod_enable), 32'h01);
    chk("add_valid", 32'(out_valid), 32'd1);
    step(0, 5'd0, 0);
    chk("add_busy_after", 32'(busy), 32'd0);

    // SUB, AND, SRA back-to-back
    step(1, 5'd1, 0);
    chk("b2b_op1", 32'(out_opcode), 32'd1);
    chk("b2b_rdy1", 32'(in_ready), 32'd1);
    step(1, 5'd2, 0);
    chk("b2b_op2", 32'(out_opcode), 32'd2);
    step(1, 5'd5, 0);
    chk("b2b_op3", 32'(out_opcode), 32'd5);
    chk("b2b_valid3", 32'(out_valid), 32'd1);
    step(0, 5'd0, 0);

    // MUL, unit_done 4 cycles after mod_start (ties with timeout: done wins)
    step(1, 5'd6, 0);
    chk("mul_start", 32'(mod_start), 32'd1);
    chk("mul_en", 32'(mod_enable), 32'h40);
    chk("mul_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 5'd0, 0);
      chk("mul_en_hold", 32'(mod_enable), 32'h40);
      chk("mul_no_valid", 32'(out_valid), 32'd0);
    end
    step(0, 5'd0, 1);
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_done_to", 32'(timed_out), 32'd0);
    chk("mul_done_en", 32'(mod_enable), 32'h40);
    step(0, 5'd0, 0);

    // DIV times out, next op accepted in DONE
    step(1, 5'd7, 0);
    step(0, 5'd0, 1);  // done during mod_start cycle is ignored
    chk("div_ign_done", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 5'd0, 0);
    step(0, 5'd0, 0);
    chk("div_to_valid", 32'(out_valid), 32'd1);
    chk("div_to_flag", 32'(timed_out), 32'd1);
    chk("div_to_ready", 32'(in_ready), 32'd1);
    step(1, 5'd0, 0);
    chk("div_next_en", 32'(mod_enable), 32'h01);
    chk("div_next_to", 32'(timed_out), 32'd0);
    step(0, 5'd0, 0);

    // Illegal opcode
    step(1, 5'd20, 0);
    chk("ill_en", 32'(mod_enable), 32'h00);
    chk("ill_valid", 32'(out_valid), 32'd1);
`ifdef ALU_SEQ_ILLEGAL_EN
    chk("ill_flag", 32'(illegal), 32'd1);
`endif
    step(0, 5'd0, 0);

    // Reset mid-MUL, then a stray unit_done
    step(1, 5'd6, 0);
    step(0, 5'd0, 0);
    reset = 1'b1;
    #1;
    chk("rmid_en", 32'(mod_enable), 32'h00);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_ready", 32'(in_ready), 32'd0);
    chk("rmid_valid", 32'(out_valid), 32'd0);
    step(0, 5'd0, 1);
    reset = 1'b0;
    step(0, 5'd0, 1);
    chk("rpost_valid", 32'(out_valid), 32'd0);
    chk("rpost_busy", 32'(busy), 32'd0);
    step(0, 5'd0, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
      step($urandom_range(0, 2) != 0, op, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
